rr_arb_mux: RTL and testbench

Parametrised N-input, registered, round-robin arbitrating multiplexer with a valid/ready handshake on every input and on the output. It is the successor to the fixed 2/3/4-input select muxes. Instead of taking an external select, it chooses fairly among requesting sources, buffers one result, and reports which source won. It sits where several producers share one consumer, for example multiple request sources feeding a single memory or bus port in the pipelined CPU.

---
 rtl/rr_mux_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rr_arb_mux.sv | 110 +++++++++++
 tb/tb_rr_arb_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin arbitrating mux: index width derivation
// and the output holding register state encoding.
package rr_mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single channel still needs a one-bit index port.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam logic ST_EMPTY_ENC = 1'b0;
  localparam logic ST_FULL_ENC  = 1'b1;

  typedef enum logic {
    ST_EMPTY = ST_EMPTY_ENC,
    ST_FULL  = ST_FULL_ENC
  } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, with
// wrap-around. ptr is assumed to be below NUM_IN.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input registered round-robin arbitrating mux with valid/ready on every side.
// Optional RR_MUX_FORCE_SEL_EN adds force_en/force_sel for external-select use.
//
// state    | meaning
// ST_EMPTY | output register holds nothing, out_valid=0
// ST_FULL  | output register holds a word, out_valid=1
module rr_arb_mux
  import rr_mux_pkg::*;
#(
  parameter  int DATAWIDTH = 32,
  parameter  int NUM_IN    = 4,
  localparam int SEL_W     = sel_w(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
`ifdef RR_MUX_FORCE_SEL_EN
  ,
  input  logic                        force_en,
  input  logic [SEL_W-1:0]            force_sel
`endif
);

  out_state_t           state, state_nx;
  logic [SEL_W-1:0]     ptr, ptr_nx;
  logic [NUM_IN-1:0]    req_elig;
  logic [NUM_IN-1:0]    grant;
  logic [SEL_W-1:0]     grant_idx;
  logic                 any_grant;
  logic                 load_ok;
  logic                 accept;
  logic                 ptr_upd;
  logic [DATAWIDTH-1:0] sel_data;

`ifdef RR_MUX_FORCE_SEL_EN
  // Forcing narrows eligibility to one channel; an out-of-range index grants nothing.
  always_comb begin
    req_elig = '0;
    if (force_en) begin
      if (int'(force_sel) < NUM_IN) req_elig[force_sel] = in_valid[force_sel];
    end else begin
      req_elig = in_valid;
    end
  end
  assign ptr_upd = ~force_en;
`else
  assign req_elig = in_valid;
  assign ptr_upd  = 1'b1;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req       (req_elig),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign out_valid = (state == ST_FULL);
  // Reset also closes the input side so nothing is accepted while it is held.
  assign load_ok   = (~out_valid | out_ready) & ~reset;
  assign accept    = any_grant & load_ok;
  assign in_ready  = load_ok ? grant : '0;
  assign ptr_nx    = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  // AND-OR mux driven by the one-hot grant keeps in_data off any output path.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) sel_data = sel_data | in_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (accept) state_nx = ST_FULL;
      ST_FULL: begin
        if (accept)         state_nx = ST_FULL;
        else if (out_ready) state_nx = ST_EMPTY;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
        if (ptr_upd) ptr <= ptr_nx;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (default build, 4 x 32-bit channels).
module tb_rr_arb_mux;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready = 1'b0;

  always #5 clk = ~clk;

  rr_arb_mux #(.DATAWIDTH(DW), .NUM_IN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            m_ptr = 0;
  bit            m_full = 1'b0;
  int            last_acc = -1;
  logic [DW-1:0] chd[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, compare handshake against the model,
  // then advance the model to what the coming posedge should do.
  task automatic cycle(input logic [N-1:0] v, input bit rdy, input bit rst);
    int           win;
    int           c;
    bit           lok;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = chd[i];
    #1;
    win = -1;
    lok = !rst && (!m_full || rdy);
    if (lok) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && v[c]) win = c;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    if (rst) begin
      m_ptr  = 0;
      m_full = 1'b0;
      sbq.delete();
    end else if (win >= 0) begin
      sbq.push_back('{win, chd[win]});
      m_ptr  = (win + 1) % N;
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
    last_acc = win;
  endtask

  // Monitor: a word is consumed when out_valid & out_ready before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid === 1'b1 && out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: unexpected word sel %0d data %0h, expected none", out_sel, out_data);
        end else begin
          e = sbq.pop_front();
          check("out_sel", {62'd0, out_sel}, 64'(e.ch));
          check("out_data", {32'd0, out_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    logic [N-1:0] pend;
    for (int i = 0; i < N; i++) chd[i] = 32'hA0 + i;

    // reset with everyone requesting
    cycle(4'hF, 1'b1, 1'b1);
    cycle(4'hF, 1'b1, 1'b1);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_sel", {62'd0, out_sel}, 64'd0);

    // round robin, all valid, no bubbles
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 1'b1, 1'b0);
      check("rr_order", {60'd0, in_ready}, 64'(1 << (k % N)));
    end

    // backpressure holding A1
    cycle(4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(4'hF, 1'b0, 1'b0);
      check("bp_hold_data", {32'd0, out_data}, 64'hA1);
    end
    cycle(4'hF, 1'b1, 1'b0);
    check("bp_release", {60'd0, in_ready}, 64'b0100);
    cycle(4'h0, 1'b1, 1'b0);

    // sparse requests with wrap (ptr is 3 here)
    cycle(4'b0010, 1'b1, 1'b0);
    check("sparse_1", {60'd0, in_ready}, 64'b0010);
    cycle(4'b1001, 1'b1, 1'b0);
    check("sparse_3", {60'd0, in_ready}, 64'b1000);
    cycle(4'b0001, 1'b1, 1'b0);
    check("sparse_0", {60'd0, in_ready}, 64'b0001);

    // reset mid-stream while holding channel 2
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'hF, 1'b0, 1'b1);
    cycle(4'hF, 1'b0, 1'b0);
    check("post_rst_ptr", {60'd0, in_ready}, 64'b0001);
    cycle(4'h0, 1'b1, 1'b0);

    // randomized traffic with held data and occasional reset
    pend = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          chd[i]  = $urandom;
        end
      end
      cycle(pend, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
      if (last_acc >= 0) pend[last_acc] = 1'b0;
    end

    cycle(4'h0, 1'b1, 1'b0);
    cycle(4'h0, 1'b1, 1'b0);
    check("final_drain", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
